// File: rtl/seg_scan_driver_pkg.sv
// Shared widths, codes, conversion state encoding and the display formatting helper
// for the seven-segment scan driver.
`default_nettype none

package seg_scan_driver_pkg;

  localparam int         SEG_DIGITS = 4;
  localparam logic [3:0] BCD_MINUS  = 4'd10;
  localparam int         VAL_W      = 14;
  localparam int         BCD_W      = 4 * SEG_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic [SEG_DIGITS-1:0][3:0] code;
    logic [SEG_DIGITS-1:0]      blank;
  } disp_t;

  // Range check, minus placement and leading-zero blanking for one converted value.
  function automatic disp_t format_digits(
    input logic [BCD_W-1:0] bcd,
    input logic [VAL_W-1:0] val,
    input logic             neg,
    input logic             lzb
  );
    disp_t r;
    logic  is_neg;
    logic  ovf;
    logic  zrun;
    is_neg  = neg && (val != '0);
    ovf     = is_neg ? (val > VAL_W'(999)) : (val > VAL_W'(9999));
    r.blank = '0;
    zrun    = 1'b1;
    for (int i = 0; i < SEG_DIGITS; i++) begin
      r.code[i] = ovf ? BCD_MINUS : bcd[4*i +: 4];
    end
    if (!ovf) begin
      if (is_neg) begin
        r.code[SEG_DIGITS-1] = BCD_MINUS;
      end
      // The minus digit never joins the zero run, so blanking starts below it.
      for (int i = SEG_DIGITS - 1; i >= 1; i--) begin
        if (!(is_neg && (i == SEG_DIGITS - 1))) begin
          zrun       = zrun && (r.code[i] == 4'd0);
          r.blank[i] = lzb && zrun;
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle, then a
// single CHECK cycle during which done_o is high and bcd_o holds the result.
`default_nettype none

module bin2bcd_seq
  import seg_scan_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [VAL_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int         SR_W      = BCD_W + VAL_W;
  localparam logic [3:0] LAST_ITER = 4'(VAL_W - 1);

  conv_state_e     state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [SR_W-1:0] sr_adj;
  logic [3:0]      iter_q, iter_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    sr_adj  = sr_q;
    for (int i = 0; i < SEG_DIGITS; i++) begin
      if (sr_q[VAL_W+4*i +: 4] >= 4'd5) begin
        sr_adj[VAL_W+4*i +: 4] = sr_q[VAL_W+4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sr_d    = {{BCD_W{1'b0}}, value_i};
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = {sr_adj[SR_W-2:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_CHECK);
  assign bcd_o  = sr_q[SR_W-1:VAL_W];

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment feeder: captures a signed magnitude, converts it to BCD
// and time-multiplexes the formatted digits onto active-low anodes plus a digit code.
`default_nettype none

module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZB         = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  neg,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic [SEG_DIGITS-1:0] an,
  output logic [3:0]            bcd
);

  localparam int          PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam disp_t       DISP_RESET = '{code: '0, blank: '1};

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be at least 2");
  end

  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             accept;

  logic             neg_q, neg_d;
  logic [VAL_W-1:0] val_q, val_d;
  disp_t            disp_q, disp_d;

  logic [PW-1:0]           presc_q, presc_d;
  logic [1:0]              idx_q, idx_d;
  logic [SEG_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              bcd_q, bcd_d;

  assign accept = load && !conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .value_i (value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q   <= 1'b0;
      val_q   <= '0;
      disp_q  <= DISP_RESET;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      bcd_q   <= '0;
    end else begin
      neg_q   <= neg_d;
      val_q   <= val_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
    end
  end

  // All four digits and their blank flags swap in together on the CHECK cycle.
  always_comb begin
    neg_d  = neg_q;
    val_d  = val_q;
    disp_d = disp_q;
    if (accept) begin
      neg_d = neg;
      val_d = value;
    end
    if (conv_done) begin
      disp_d = format_digits(conv_bcd, val_q, neg_q, LZB);
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    an_d  = disp_q.blank[idx_q] ? '1 : ~(SEG_DIGITS'(1) << idx_q);
    bcd_d = disp_q.code[idx_q];
  end

  assign busy = conv_busy;
  assign an   = an_q;
  assign bcd  = bcd_q;

endmodule

`default_nettype wire
